// File: rtl/uart_config_sequencer_if.sv
// TX/RX handshake bundle between the config sequencer (master) and the UART datapaths (slave).
interface uart_config_sequencer_if;
  logic [7:0] tx_data_o;
  logic       tx_req_o;
  logic       tx_done_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;

  modport master (
    output tx_data_o, tx_req_o,
    input  tx_done_i, rx_data_i, rx_valid_i
  );

  modport slave (
    input  tx_data_o, tx_req_o,
    output tx_done_i, rx_data_i, rx_valid_i
  );
endinterface

// File: rtl/uart_config_sequencer.sv
// Sends DATA_WIDTH, PARITY_MODE, STOP_BITS and END_CONFIG packets, waits for an 8'hFF ack after
// each one with timeout/NAK retries, and commits the requested configuration on success.
module uart_config_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           start_i,
  input  logic [5:0]                     cfg_i,
  uart_config_sequencer_if.master        link,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           error_o,
  output logic [3:0]                     int_id_o,
  output logic [5:0]                     cfg_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [5:0]    CFG_RESET  = 6'b11_00_00;

  typedef enum logic [2:0] {IDLE, CHECK, SEND, WAIT_TX, WAIT_ACK, COMMIT, FAIL} state_e;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [5:0]      cfg_req_q, cfg_req_d;
  logic [5:0]      cfg_act_q, cfg_act_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_req_q, tx_req_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [3:0]      int_id_q, int_id_d;

  function automatic logic [7:0] packet(input logic [1:0] i, input logic [5:0] c);
    case (i)
      2'd0:    packet = {4'b0000, c[5:4], 2'b01};
      2'd1:    packet = {4'b0000, c[3:2], 2'b10};
      2'd2:    packet = {4'b0000, c[1:0], 2'b11};
      default: packet = 8'h00;
    endcase
  endfunction

  // Registered outputs are loaded on the transition into a state, so tx_req_o is already high
  // while in SEND and the done/error pulses line up with COMMIT/FAIL.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    cfg_req_d = cfg_req_q;
    cfg_act_d = cfg_act_q;
    tx_data_d = tx_data_q;
    tx_req_d  = tx_req_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    int_id_d  = 4'b0000;

    case (state_q)
      IDLE, COMMIT, FAIL: begin
        state_d = IDLE;
        if (start_i) begin
          cfg_req_d = cfg_i;
          idx_d     = 2'd0;
          retry_d   = '0;
          busy_d    = 1'b1;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (cfg_req_q[1]) begin
          error_d  = 1'b1;
          int_id_d = 4'b0001;
          busy_d   = 1'b0;
          state_d  = FAIL;
        end else begin
          tx_req_d  = 1'b1;
          tx_data_d = packet(idx_q, cfg_req_q);
          state_d   = SEND;
        end
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: begin
        if (link.tx_done_i) begin
          tx_req_d = 1'b0;
          timer_d  = '0;
          state_d  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        timer_d = timer_q + 1'b1;
        if (link.rx_valid_i && link.rx_data_i == 8'hFF) begin
          if (idx_q == 2'd3) begin
            cfg_act_d = cfg_req_q;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = COMMIT;
          end else begin
            idx_d     = idx_q + 2'd1;
            retry_d   = '0;
            tx_req_d  = 1'b1;
            tx_data_d = packet(idx_q + 2'd1, cfg_req_q);
            state_d   = SEND;
          end
        end else if (link.rx_valid_i || timer_q == TIMER_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d  = retry_q + 1'b1;
            tx_req_d = 1'b1;
            state_d  = SEND;
          end else begin
            error_d  = 1'b1;
            int_id_d = 4'b0001;
            busy_d   = 1'b0;
            state_d  = FAIL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      retry_q   <= '0;
      timer_q   <= '0;
      cfg_req_q <= CFG_RESET;
      cfg_act_q <= CFG_RESET;
      tx_data_q <= 8'h00;
      tx_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      int_id_q  <= 4'b0000;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
      cfg_req_q <= cfg_req_d;
      cfg_act_q <= cfg_act_d;
      tx_data_q <= tx_data_d;
      tx_req_q  <= tx_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      int_id_q  <= int_id_d;
    end
  end

  assign link.tx_data_o = tx_data_q;
  assign link.tx_req_o  = tx_req_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign int_id_o       = int_id_q;
  assign cfg_o          = cfg_act_q;

endmodule

// File: tb/tb_uart_config_sequencer.sv
// Randomized bench for uart_config_sequencer: a cycle-level TX/RX responder plays out a reply plan
// produced by a packet-level model, and every observed packet/pulse is scored against that model.
module tb_uart_config_sequencer;

  localparam int ACK     = 0;
  localparam int NAK     = 1;
  localparam int SIL     = 2;
  localparam int ACK_EXP = 3;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] cfg_in;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] int_id;
  logic [5:0] cfg_out;

  uart_config_sequencer_if link_if();

  uart_config_sequencer #(.TIMEOUT_CYCLES(100), .MAX_RETRY(2)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .start_i  (start),
    .cfg_i    (cfg_in),
    .link     (link_if),
    .busy_o   (busy),
    .done_o   (done),
    .error_o  (error),
    .int_id_o (int_id),
    .cfg_o    (cfg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks;
  int         failures;
  logic [7:0] exp_pkts[$];
  int         plan_q[$];
  int         force_q[$];
  bit         exp_done;
  bit         rand_mode;
  logic [5:0] committed;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Packet-level view: which bytes go out, in what order, and how the sequence ends.
  task automatic buildModel(input logic [5:0] cfg);
    int c, idx, retry, code, r, field;
    plan_q.delete();
    exp_pkts.delete();
    exp_done = 0;
    c = int'(cfg);
    if (c % 4 >= 2) return;
    idx = 0;
    retry = 0;
    forever begin
      if (idx == 3) exp_pkts.push_back(8'h00);
      else begin
        field = (c >> (4 - 2 * idx)) % 4;
        exp_pkts.push_back(8'(field * 4 + idx + 1));
      end
      if (force_q.size() > 0) code = force_q.pop_front();
      else if (rand_mode) begin
        r = $urandom_range(0, 99);
        code = (r < 60) ? ACK : (r < 75) ? NAK : (r < 90) ? SIL : ACK_EXP;
      end else code = ACK;
      plan_q.push_back(code);
      if (code == ACK || code == ACK_EXP) begin
        if (idx == 3) begin
          exp_done = 1;
          break;
        end
        idx++;
        retry = 0;
      end else if (retry < 2) retry++;
      else break;
    end
  endtask

  task automatic applyStimulus(input logic [5:0] cfg, input bit inject_start);
    int req_seen, done_at, rx_at, expect_req_at, code;
    logic [7:0] rx_byte, held_data;
    bit prev_req, finished, legal;
    legal = (cfg[1] == 1'b0);
    buildModel(cfg);
    req_seen = 0; done_at = -1; rx_at = -1; expect_req_at = -1;
    prev_req = 0; finished = 0; rx_byte = 8'h00; held_data = 8'h00;
    @(negedge clk);
    start = 1'b1;
    cfg_in = cfg;
    for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      link_if.tx_done_i = 1'b0;
      link_if.rx_valid_i = 1'b0;
      link_if.rx_data_i = 8'($urandom);
      if (cyc == 1) checkOutput("busy_after_start", int'(busy), 1);
      if (link_if.tx_req_o && !prev_req) begin
        if (req_seen == 0) checkOutput("first_req_latency", cyc, 2);
        if (expect_req_at >= 0) checkOutput("next_req_time", cyc, expect_req_at);
        if (exp_pkts.size() == 0) checkOutput("extra_pkt", int'(link_if.tx_data_o), -1);
        else checkOutput("pkt", int'(link_if.tx_data_o), int'(exp_pkts.pop_front()));
        req_seen++;
        held_data = link_if.tx_data_o;
        done_at = cyc + int'($urandom_range(1, 4));
        expect_req_at = -1;
      end else if (link_if.tx_req_o) begin
        checkOutput("tx_data_stable", int'(link_if.tx_data_o), int'(held_data));
      end
      prev_req = link_if.tx_req_o;
      if (link_if.tx_req_o && $urandom_range(0, 3) == 0) begin
        link_if.rx_valid_i = 1'b1;
        link_if.rx_data_i = 8'hFF;
      end
      if (cyc == done_at) begin
        link_if.tx_done_i = 1'b1;
        code = (plan_q.size() > 0) ? plan_q.pop_front() : SIL;
        rx_byte = (code == NAK) ? 8'($urandom_range(0, 254)) : 8'hFF;
        case (code)
          ACK, NAK: rx_at = cyc + int'($urandom_range(1, 80));
          ACK_EXP:  rx_at = cyc + 100;
          default:  rx_at = -1;
        endcase
        expect_req_at = (code == SIL) ? cyc + 101 : rx_at + 1;
      end
      if (cyc == rx_at) begin
        link_if.rx_valid_i = 1'b1;
        link_if.rx_data_i = rx_byte;
      end
      if (inject_start && cyc == 30 && busy) begin
        start = 1'b1;
        cfg_in = ~cfg;
      end
      if (done) begin
        checkOutput("done_expected", 1, int'(exp_done));
        checkOutput("done_latency", cyc, rx_at + 1);
        checkOutput("cfg_committed", int'(cfg_out), int'(cfg));
        checkOutput("busy_at_done", int'(busy), 0);
        checkOutput("pkts_left", exp_pkts.size(), 0);
        committed = cfg;
        finished = 1;
      end
      if (error) begin
        checkOutput("error_expected", 1, int'(!exp_done));
        checkOutput("int_id_on_error", int'(int_id), 1);
        checkOutput("cfg_kept", int'(cfg_out), int'(committed));
        checkOutput("busy_at_error", int'(busy), 0);
        checkOutput("pkts_left", exp_pkts.size(), 0);
        if (!legal) begin
          checkOutput("illegal_err_latency", cyc, 2);
          checkOutput("illegal_no_tx", req_seen, 0);
        end
        finished = 1;
      end
    end
    if (!finished) checkOutput("cycle_budget", 0, 1);
    @(negedge clk);
    start = 1'b0;
    link_if.tx_done_i = 1'b0;
    link_if.rx_valid_i = 1'b0;
    checkOutput("idle_done", int'(done), 0);
    checkOutput("idle_error", int'(error), 0);
    checkOutput("idle_int_id", int'(int_id), 0);
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("idle_tx_req", int'(link_if.tx_req_o), 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_tx_req"}, int'(link_if.tx_req_o), 0);
    checkOutput({tag, "_tx_data"}, int'(link_if.tx_data_o), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_error"}, int'(error), 0);
    checkOutput({tag, "_int_id"}, int'(int_id), 0);
    checkOutput({tag, "_cfg"}, int'(cfg_out), 'h30);
  endtask

  task automatic resetMidSequence();
    int pulses;
    @(negedge clk);
    start = 1'b1;
    cfg_in = 6'b10_01_00;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      link_if.tx_done_i = (cyc == 4);
      if (cyc == 10) begin
        checkOutput("pre_reset_busy", int'(busy), 1);
        checkOutput("pre_reset_tx_req", int'(link_if.tx_req_o), 0);
        rst_n = 1'b0;
      end
    end
    @(negedge clk);
    checkResetValues("mid_reset");
    rst_n = 1'b1;
    committed = 6'b11_00_00;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || error || busy) pulses++;
    end
    checkOutput("no_activity_after_reset", pulses, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rand_mode = 0;
    rst_n = 1'b0;
    start = 1'b0;
    cfg_in = 6'b0;
    link_if.tx_done_i = 1'b0;
    link_if.rx_valid_i = 1'b0;
    link_if.rx_data_i = 8'h00;
    committed = 6'b11_00_00;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    $display("[TB] all packets acked");
    applyStimulus(6'b11_01_01, 0);

    $display("[TB] silent receiver after second packet");
    force_q.push_back(ACK); force_q.push_back(SIL); force_q.push_back(SIL); force_q.push_back(SIL);
    applyStimulus(6'b01_10_00, 0);

    $display("[TB] NAK then acks");
    force_q.push_back(NAK);
    applyStimulus(6'b00_10_00, 0);

    $display("[TB] reserved stop bits");
    applyStimulus(6'b11_00_10, 0);

    $display("[TB] acks on timer expiry, start pulse while busy");
    repeat (4) force_q.push_back(ACK_EXP);
    applyStimulus(6'b10_11_01, 1);

    $display("[TB] reset during ack wait");
    resetMidSequence();

    $display("[TB] randomized sequences");
    rand_mode = 1;
    repeat (12) applyStimulus(6'($urandom), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
